// File: rtl/jtag_shifter_pkg.sv
// Shared encodings for the JTAG shifter: command opcodes, controller states
// and the length of the TMS-high run used by the RESET command.
package jtag_shifter_pkg;

  typedef enum logic [1:0] {
    OP_RESET     = 2'd0,
    OP_TMS_SEQ   = 2'd1,
    OP_SCAN      = 2'd2,
    OP_SCAN_FLIP = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOW,
    ST_HIGH,
    ST_PUSH,
    ST_END
  } state_e;

  localparam int RESET_TMS_CYCLES = 5;

  function automatic logic op_captures(op_e op);
    return (op == OP_SCAN) || (op == OP_SCAN_FLIP);
  endfunction

endpackage

// File: rtl/jtag_tck_div.sv
// TCK half-period timer: a down-counter reloaded at the start of each phase,
// flagging the last clk cycle of the phase with a one-cycle pulse.
module jtag_tck_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             active,
  input  logic [DIV_W-1:0] div,
  output logic             phase_end
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = div;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign phase_end = active && (cnt_q == '0);

endmodule

// File: rtl/jtag_shifter.sv
// Command-driven JTAG shifter: RESET, TMS sequences and TDI/TDO scans with
// LSB-first word streaming. Define JTAG_SHIFTER_TDO_NEG_EN to sample TDO on
// the falling TCK edge instead of the rising one.
//
// state | meaning
// IDLE  | waiting for a command, last dout word already taken
// FETCH | waiting for the next din word
// LOW   | TCK low half period, tms/tdi freshly driven
// HIGH  | TCK high half period
// PUSH  | presenting a captured word on dout
// END   | one cycle with tck/tms/tdi all low
module jtag_shifter
  import jtag_shifter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIV_W-1:0]  tck_div,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [CNT_W-1:0]  cmd_len,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic [DATA_W-1:0] din,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [DATA_W-1:0] dout,
  output logic              tck,
  output logic              tms,
  output logic              tdi,
  input  logic              tdo,
  output logic              busy
);

  localparam int POS_W = $clog2(DATA_W);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(DATA_W - 1);

`ifdef JTAG_SHIFTER_TDO_NEG_EN
  localparam bit TDO_NEG = 1'b1;
`else
  localparam bit TDO_NEG = 1'b0;
`endif

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [DATA_W-1:0] cap_q, cap_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              tck_q, tck_d;
  logic              tms_q, tms_d;
  logic              tdi_q, tdi_d;
  logic              phase_end;
  logic              phase_load;
  logic              cmd_fire;

  assign cmd_fire   = cmd_valid && cmd_ready;
  assign phase_load = ((state_d == ST_LOW) || (state_d == ST_HIGH)) && (state_d != state_q);

  jtag_tck_div #(.DIV_W(DIV_W)) u_tck_div (
    .clk       (clk),
    .rst       (rst),
    .load      (phase_load),
    .active    ((state_q == ST_LOW) || (state_q == ST_HIGH)),
    .div       (div_d),
    .phase_end (phase_end)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    rem_d        = rem_q;
    pos_d        = pos_q;
    div_d        = div_q;
    word_d       = word_q;
    cap_d        = cap_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    tms_d        = tms_q;
    tdi_d        = tdi_q;

    if (dout_valid_q && dout_ready) begin
      dout_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          op_d  = op_e'(cmd_op);
          div_d = tck_div;
          pos_d = '0;
          cap_d = '0;
          if (op_d == OP_RESET) begin
            rem_d   = CNT_W'(RESET_TMS_CYCLES + 1);
            state_d = ST_LOW;
          end else if (cmd_len == '0) begin
            state_d = ST_END;
          end else begin
            rem_d   = cmd_len;
            state_d = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        if (din_valid) begin
          word_d  = din;
          state_d = ST_LOW;
        end
      end
      ST_LOW: begin
        if (phase_end) begin
          if (!TDO_NEG && op_captures(op_q)) cap_d[pos_q] = tdo;
          state_d = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (phase_end) begin
          if (TDO_NEG && op_captures(op_q)) cap_d[pos_q] = tdo;
          rem_d = rem_q - 1'b1;
          pos_d = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
          if (rem_q == CNT_W'(1)) begin
            state_d = op_captures(op_q) ? ST_PUSH : ST_END;
          end else if ((op_q != OP_RESET) && (pos_q == POS_LAST)) begin
            state_d = op_captures(op_q) ? ST_PUSH : ST_FETCH;
          end else begin
            state_d = ST_LOW;
          end
        end
      end
      ST_PUSH: begin
        // Stall here while the previous word is still unclaimed.
        if (!dout_valid_q || dout_ready) begin
          dout_d       = cap_q;
          dout_valid_d = 1'b1;
          cap_d        = '0;
          state_d      = (rem_q == '0) ? ST_END : ST_FETCH;
        end
      end
      ST_END: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if ((state_d == ST_LOW) && (state_q != ST_LOW)) begin
      case (op_d)
        OP_RESET: begin
          tms_d = (rem_d > CNT_W'(1));
          tdi_d = 1'b0;
        end
        OP_TMS_SEQ: begin
          tms_d = word_d[pos_d];
          tdi_d = 1'b0;
        end
        OP_SCAN: begin
          tms_d = 1'b0;
          tdi_d = word_d[pos_d];
        end
        default: begin
          tms_d = (rem_d == CNT_W'(1));
          tdi_d = word_d[pos_d];
        end
      endcase
    end

    if (state_d == ST_END) begin
      tms_d = 1'b0;
      tdi_d = 1'b0;
    end

    tck_d = (state_d == ST_HIGH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_RESET;
      rem_q        <= '0;
      pos_q        <= '0;
      div_q        <= '0;
      word_q       <= '0;
      cap_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      tck_q        <= 1'b0;
      tms_q        <= 1'b0;
      tdi_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      rem_q        <= rem_d;
      pos_q        <= pos_d;
      div_q        <= div_d;
      word_q       <= word_d;
      cap_q        <= cap_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      tck_q        <= tck_d;
      tms_q        <= tms_d;
      tdi_q        <= tdi_d;
    end
  end

  assign cmd_ready  = (state_q == ST_IDLE) && !dout_valid_q;
  assign din_ready  = (state_q == ST_FETCH);
  assign dout_valid = dout_valid_q;
  assign dout       = dout_q;
  assign tck        = tck_q;
  assign tms        = tms_q;
  assign tdi        = tdi_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_jtag_shifter.sv
// Directed plus randomized bench for jtag_shifter; expected TCK bit streams
// and dout words are derived from the command semantics, not the RTL.
module tb_jtag_shifter;

  localparam int DW = 32;
  localparam int CW = 16;
  localparam int VW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [VW-1:0] tck_div;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_op;
  logic [CW-1:0] cmd_len;
  logic          din_valid, din_ready;
  logic [DW-1:0] din;
  logic          dout_valid, dout_ready;
  logic [DW-1:0] dout;
  logic          tck, tms, tdi, tdo, busy;
  logic          loop_en, tdo_r;

  assign tdo = loop_en ? tdi : tdo_r;

  always #5 clk = ~clk;

  jtag_shifter #(.DATA_W(DW), .CNT_W(CW), .DIV_W(VW)) dut (
    .clk        (clk),
    .rst        (rst),
    .tck_div    (tck_div),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_len    (cmd_len),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .din        (din),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout       (dout),
    .tck        (tck),
    .tms        (tms),
    .tdi        (tdi),
    .tdo        (tdo),
    .busy       (busy)
  );

  int            n_pass = 0;
  int            n_total = 0;
  logic [DW-1:0] words [8];
  logic [255:0]  tdo_bits;
  logic [255:0]  obs_tms, obs_tdi, exp_tms, exp_tdi;
  int            rise_n, din_n, exp_rise, exp_din;
  logic [DW-1:0] got_q[$];
  logic [DW-1:0] exp_q[$];
  int            rise_cyc[$];
  logic          rel_tck;
  int            rel_rise;
  bit            run_done;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: bit i of the stream is bit (i mod DW) of word (i / DW).
  task automatic build_exp(input int op, input int len);
    logic [DW-1:0] w;
    exp_tms = '0;
    exp_tdi = '0;
    exp_q.delete();
    if (op == 0) begin
      exp_rise = 6;
      exp_din  = 0;
      exp_tms  = 256'h1f;
    end else begin
      exp_rise = len;
      exp_din  = (len + DW - 1) / DW;
      for (int i = 0; i < len; i++) begin
        if (op == 1) exp_tms[i] = words[i / DW][i % DW];
        else         exp_tdi[i] = words[i / DW][i % DW];
      end
      if (op == 3 && len > 0) exp_tms[len-1] = 1'b1;
      if (op >= 2) begin
        for (int k = 0; k < exp_din; k++) begin
          w = '0;
          for (int j = 0; j < DW && (k * DW + j) < len; j++)
            w[j] = loop_en ? exp_tdi[k*DW+j] : tdo_bits[k*DW+j];
          exp_q.push_back(w);
        end
      end
    end
  endtask

  // rmode: 0 dout_ready high, 1 random ready/valid, 2 dout_ready held low 200 cycles
  task automatic run_cmd(input int op, input int len, input int div, input int rmode,
                         input int abort_at);
    bit            accepted, hs_din, hs_dout, hs_cmd, hold_on;
    logic          tck_prev;
    logic [DW-1:0] dsnap;
    int            hold_left, t;
    obs_tms = '0; obs_tdi = '0; rise_n = 0; din_n = 0;
    got_q.delete(); rise_cyc.delete();
    tdo_r = tdo_bits[0];
    cmd_op = op[1:0]; cmd_len = CW'(len); tck_div = VW'(div); cmd_valid = 1'b1;
    accepted = 0; hold_on = 0; hold_left = 200; tck_prev = tck; run_done = 0;
    rel_tck = 1'bx; rel_rise = -1;
    for (t = 0; t < 20000; t++) begin
      din_valid = (din_n < 8) && (rmode != 1 || $urandom_range(0, 3) != 0);
      din = (din_n < 8) ? words[din_n] : '0;
      case (rmode)
        1: dout_ready = ($urandom_range(0, 1) == 1);
        2: begin
          if (dout_valid) hold_on = 1;
          if (hold_on && hold_left > 0) begin
            dout_ready = 1'b0;
            hold_left--;
            if (hold_left == 0) begin rel_tck = tck; rel_rise = rise_n; end
          end else dout_ready = 1'b1;
        end
        default: dout_ready = 1'b1;
      endcase
      hs_din = din_valid && din_ready;
      hs_dout = dout_valid && dout_ready;
      hs_cmd = cmd_valid && cmd_ready;
      dsnap = dout;
      if (abort_at > 0 && t == abort_at) rst = 1'b1;
      @(posedge clk); #1;
      if (rst) begin
        rst = 1'b0;
        cmd_valid = 1'b0;
        run_done = 1;
        return;
      end
      if (hs_cmd) begin cmd_valid = 1'b0; accepted = 1; end
      if (hs_din) din_n++;
      if (hs_dout) got_q.push_back(dsnap);
      if (tck && !tck_prev) begin
        if (rise_n < 256) begin obs_tms[rise_n] = tms; obs_tdi[rise_n] = tdi; end
        rise_cyc.push_back(t);
`ifdef JTAG_SHIFTER_TDO_NEG_EN
        if (rise_n < 256) tdo_r = tdo_bits[rise_n];
`endif
        rise_n++;
      end
`ifndef JTAG_SHIFTER_TDO_NEG_EN
      if (!tck && tck_prev && rise_n < 256) tdo_r = tdo_bits[rise_n];
`endif
      tck_prev = tck;
      if (accepted && !busy && !dout_valid) begin run_done = 1; break; end
    end
  endtask

  task automatic check_cmd(input string name, input int op, input int len);
    logic [DW-1:0] g;
    build_exp(op, len);
    chk({name, "_done"}, run_done, 1'b1);
    chk({name, "_rises"}, rise_n, exp_rise);
    chk({name, "_tms"}, obs_tms, exp_tms);
    chk({name, "_tdi"}, obs_tdi, exp_tdi);
    chk({name, "_din_cnt"}, din_n, exp_din);
    chk({name, "_dout_cnt"}, got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++) begin
      g = (k < got_q.size()) ? got_q[k] : 'x;
      chk($sformatf("%s_dout%0d", name, k), g, exp_q[k]);
    end
    chk({name, "_idle_pins"}, {tck, tms, tdi, busy, cmd_ready}, 5'b00001);
  endtask

  task automatic rand_words();
    for (int i = 0; i < 8; i++) words[i] = $urandom();
    tdo_bits = {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  initial begin
    int op, len, div;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_len = '0; tck_div = '0;
    din_valid = 1'b0; din = '0; dout_ready = 1'b0; loop_en = 1'b1; tdo_r = 1'b0;
    rand_words();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pins", {tck, tms, tdi, cmd_ready, din_ready, dout_valid, busy}, 7'b0001000);
    chk("reset_dout", dout, '0);
    rst = 1'b0;

    for (int d = 0; d <= 2; d += 2) begin
      run_cmd(0, 0, d, 0, 0);
      check_cmd($sformatf("reset_div%0d", d), 0, 0);
      for (int i = 1; i < rise_cyc.size(); i++)
        chk($sformatf("reset_div%0d_gap%0d", d, i), rise_cyc[i] - rise_cyc[i-1], 2 * (d + 1));
    end

    words[0] = 32'hDEADBEEF; words[1] = 32'h000000A5;
    run_cmd(2, 40, 0, 0, 0);
    check_cmd("scan40", 2, 40);

    rand_words();
    run_cmd(3, 8, 1, 0, 0);
    check_cmd("flip8", 3, 8);

    words[0] = 32'h0000001F;
    run_cmd(1, 6, 0, 0, 0);
    check_cmd("tms6", 1, 6);

    rand_words();
    run_cmd(2, 64, 0, 2, 0);
    check_cmd("bp64", 2, 64);
    chk("bp64_stall_tck", rel_tck, 1'b0);
    chk("bp64_stall_rises", rel_rise, 64);

    run_cmd(2, 0, 0, 0, 0);
    check_cmd("scan0", 2, 0);

    rand_words();
    run_cmd(2, 40, 0, 0, 30);
    chk("abort_pins", {tck, tms, tdi, cmd_ready, din_ready, dout_valid, busy}, 7'b0001000);
    loop_en = 1'b0;
    run_cmd(2, 40, 0, 0, 0);
    check_cmd("after_abort", 2, 40);

    for (int r = 0; r < 6; r++) begin
      rand_words();
      op = $urandom_range(1, 3);
      len = $urandom_range(1, 120);
      div = $urandom_range(0, 2);
      loop_en = ($urandom_range(0, 1) == 1);
      run_cmd(op, len, div, 1, 0);
      check_cmd($sformatf("rand%0d_op%0d_len%0d", r, op, len), op, len);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
